// File: rtl/bpu_pkg.sv
// Shared types and helpers for the branch predictor: BTB entry layout, counter
// constants, PC index/tag extraction and saturating counter arithmetic.
package bpu_pkg;

  // Predictor geometry; the top-level parameters default to these values.
  localparam int BPU_PC_W    = 32;
  localparam int BPU_ENTRIES = 16;
  localparam int BPU_CNT_W   = 2;
  localparam int BPU_GHR_W   = 4;
  localparam int BPU_STAT_W  = 32;
  localparam int BPU_IDX_W   = $clog2(BPU_ENTRIES);
  localparam int BPU_TAG_W   = BPU_PC_W - BPU_IDX_W - 2;

  typedef logic [BPU_CNT_W-1:0] bpu_cnt_t;

  localparam bpu_cnt_t CNT_MAX    = '1;
  localparam bpu_cnt_t CNT_WEAK_T = {1'b1, {(BPU_CNT_W-1){1'b0}}};

  typedef struct packed {
    logic                 valid;
    logic [BPU_TAG_W-1:0] tag;
    logic [BPU_PC_W-1:0]  target;
    logic                 is_jump;
    bpu_cnt_t             cnt;
  } bpu_entry_t;

  function automatic logic [BPU_IDX_W-1:0] bpu_pc_index(input logic [BPU_PC_W-1:0] pc);
    return BPU_IDX_W'(pc >> 2);
  endfunction

  function automatic logic [BPU_TAG_W-1:0] bpu_pc_tag(input logic [BPU_PC_W-1:0] pc);
    return BPU_TAG_W'(pc >> (BPU_IDX_W + 2));
  endfunction

  function automatic bpu_cnt_t cnt_sat_inc(input bpu_cnt_t c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  function automatic bpu_cnt_t cnt_sat_dec(input bpu_cnt_t c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Resolved control-flow bus from execute into the branch predictor.
// Valid-only: the predictor accepts every cycle, so there is no ready signal;
// fields are meaningful only while execute_i_valid is high.
interface branch_predict_unit_if
  import bpu_pkg::*;
#(
  parameter int PC_W = BPU_PC_W
);
  logic            execute_i_valid;
  logic [PC_W-1:0] execute_i_pc;
  logic            execute_i_is_branch;
  logic            execute_i_is_jump;
  logic            execute_i_taken;
  logic [PC_W-1:0] execute_i_target;
  logic            execute_i_mispredict;

  modport master (
    output execute_i_valid, execute_i_pc, execute_i_is_branch, execute_i_is_jump,
    output execute_i_taken, execute_i_target, execute_i_mispredict
  );

  modport slave (
    input execute_i_valid, execute_i_pc, execute_i_is_branch, execute_i_is_jump,
    input execute_i_taken, execute_i_target, execute_i_mispredict
  );
endinterface

// File: rtl/bpu_entry_table.sv
// BTB storage: per-entry valid/tag/target/type/counter with two asynchronous
// read ports (fetch lookup, execute update) and one synchronous write port.
module bpu_entry_table
  import bpu_pkg::*;
#(
  parameter int ENTRIES = BPU_ENTRIES,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_lk_idx,
  output bpu_entry_t       o_lk_entry,
  input  logic [IDX_W-1:0] i_up_idx,
  output bpu_entry_t       o_up_entry,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  bpu_entry_t       i_wr_entry
);

  // Only the valid bits are reset; payload is don't-care until written.
  logic [ENTRIES-1:0] r_valid;
  bpu_entry_t         r_mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= i_wr_entry.valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_entry;
    end
  end

  always_comb begin
    o_lk_entry       = r_mem[i_lk_idx];
    o_lk_entry.valid = r_valid[i_lk_idx];
    o_up_entry       = r_mem[i_up_idx];
    o_up_entry.valid = r_valid[i_up_idx];
  end

endmodule

// File: rtl/branch_predict_unit.sv
// BTB + saturating-counter next-PC predictor with resolve/mispredict statistics.
// Optional gshare indexing is enabled by defining BPU_GSHARE_EN.
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int PC_W    = BPU_PC_W,
  parameter int ENTRIES = BPU_ENTRIES,
  parameter int CNT_W   = BPU_CNT_W,
  parameter int GHR_W   = BPU_GHR_W,
  parameter int STAT_W  = BPU_STAT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_W-1:0]       regF_i_pc,
  output logic [PC_W-1:0]       bpu_o_pre_pc,
  output logic                  bpu_o_taken,
  branch_predict_unit_if.slave  exe,
  output logic [GHR_W-1:0]      bpu_o_ghr,
  output logic [STAT_W-1:0]     bpu_o_resolve_cnt,
  output logic [STAT_W-1:0]     bpu_o_mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [IDX_W-1:0]  w_lk_idx;
  logic [IDX_W-1:0]  w_up_idx;
  bpu_entry_t        w_lk_entry;
  bpu_entry_t        w_up_entry;
  bpu_entry_t        w_wr_entry;
  logic              w_wr_en;
  logic              w_lk_hit;
  logic              w_up_hit;
  logic              w_taken;
  logic              w_upd;
  logic              w_upd_branch;
  logic [STAT_W-1:0] r_resolve_cnt;
  logic [STAT_W-1:0] r_mispred_cnt;

  // Jump wins when both type flags are set, so only pure branches shift history.
  assign w_upd        = exe.execute_i_valid && (exe.execute_i_is_branch || exe.execute_i_is_jump);
  assign w_upd_branch = w_upd && !exe.execute_i_is_jump;

`ifdef BPU_GSHARE_EN
  logic [GHR_W-1:0] r_ghr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ghr <= '0;
    end else if (w_upd_branch) begin
      r_ghr <= GHR_W'({r_ghr, exe.execute_i_taken});
    end
  end

  assign w_lk_idx  = bpu_pc_index(regF_i_pc) ^ IDX_W'(r_ghr);
  assign w_up_idx  = bpu_pc_index(exe.execute_i_pc) ^ IDX_W'(r_ghr);
  assign bpu_o_ghr = r_ghr;
`else
  assign w_lk_idx  = bpu_pc_index(regF_i_pc);
  assign w_up_idx  = bpu_pc_index(exe.execute_i_pc);
  assign bpu_o_ghr = '0;
`endif

  bpu_entry_table #(
    .ENTRIES (ENTRIES)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .i_lk_idx   (w_lk_idx),
    .o_lk_entry (w_lk_entry),
    .i_up_idx   (w_up_idx),
    .o_up_entry (w_up_entry),
    .i_wr_en    (w_wr_en),
    .i_wr_idx   (w_up_idx),
    .i_wr_entry (w_wr_entry)
  );

  // Lookup sees pre-update table contents; reset forces the fall-through guess.
  assign w_lk_hit     = w_lk_entry.valid && (w_lk_entry.tag == bpu_pc_tag(regF_i_pc));
  assign w_taken      = !rst && w_lk_hit && (w_lk_entry.is_jump || w_lk_entry.cnt[CNT_W-1]);
  assign bpu_o_taken  = w_taken;
  assign bpu_o_pre_pc = w_taken ? w_lk_entry.target : regF_i_pc + PC_W'(4);

  assign w_up_hit = w_up_entry.valid && (w_up_entry.tag == bpu_pc_tag(exe.execute_i_pc));

  always_comb begin
    w_wr_en    = 1'b0;
    w_wr_entry = w_up_entry;
    if (w_upd) begin
      if (exe.execute_i_is_jump) begin
        w_wr_en    = 1'b1;
        w_wr_entry = '{valid:   1'b1,
                       tag:     bpu_pc_tag(exe.execute_i_pc),
                       target:  exe.execute_i_target,
                       is_jump: 1'b1,
                       cnt:     CNT_MAX};
      end else if (w_up_hit) begin
        w_wr_en            = 1'b1;
        w_wr_entry.is_jump = 1'b0;
        if (exe.execute_i_taken) begin
          w_wr_entry.cnt    = cnt_sat_inc(w_up_entry.cnt);
          w_wr_entry.target = exe.execute_i_target;
        end else begin
          w_wr_entry.cnt    = cnt_sat_dec(w_up_entry.cnt);
        end
      end else if (exe.execute_i_taken) begin
        // Taken miss allocates, evicting whatever aliased into this slot.
        w_wr_en    = 1'b1;
        w_wr_entry = '{valid:   1'b1,
                       tag:     bpu_pc_tag(exe.execute_i_pc),
                       target:  exe.execute_i_target,
                       is_jump: 1'b0,
                       cnt:     CNT_WEAK_T};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_resolve_cnt <= '0;
      r_mispred_cnt <= '0;
    end else if (w_upd) begin
      if (r_resolve_cnt != '1) begin
        r_resolve_cnt <= r_resolve_cnt + 1'b1;
      end
      if (exe.execute_i_mispredict && (r_mispred_cnt != '1)) begin
        r_mispred_cnt <= r_mispred_cnt + 1'b1;
      end
    end
  end

  assign bpu_o_resolve_cnt = r_resolve_cnt;
  assign bpu_o_mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomized bench for branch_predict_unit against a behavioural predictor model;
// the model follows BPU_GSHARE_EN the same way the design does.
module tb_branch_predict_unit;

  localparam int PC_W    = 32;
  localparam int ENTRIES = 16;
  localparam int GHR_W   = 4;
  localparam int STAT_W  = 32;
  localparam longint unsigned STAT_MAX = 64'hFFFF_FFFF;

  logic              clk = 1'b0;
  logic              rst;
  logic [PC_W-1:0]   fetch_pc;
  logic [PC_W-1:0]   pre_pc;
  logic              taken;
  logic [GHR_W-1:0]  ghr;
  logic [STAT_W-1:0] resolve_cnt;
  logic [STAT_W-1:0] mispred_cnt;

  branch_predict_unit_if #(.PC_W(PC_W)) exe_bus ();

  branch_predict_unit #(
    .PC_W    (PC_W),
    .ENTRIES (ENTRIES),
    .CNT_W   (2),
    .GHR_W   (GHR_W),
    .STAT_W  (STAT_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .regF_i_pc         (fetch_pc),
    .bpu_o_pre_pc      (pre_pc),
    .bpu_o_taken       (taken),
    .exe               (exe_bus),
    .bpu_o_ghr         (ghr),
    .bpu_o_resolve_cnt (resolve_cnt),
    .bpu_o_mispred_cnt (mispred_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit              m_v   [ENTRIES];
  longint unsigned m_tag [ENTRIES];
  logic [31:0]     m_tgt [ENTRIES];
  bit              m_j   [ENTRIES];
  int              m_cnt [ENTRIES];
  int              m_ghr;
  longint unsigned m_res;
  longint unsigned m_mis;

  function automatic int m_index(input logic [31:0] pc);
    int i;
    i = int'((pc / 4) % ENTRIES);
`ifdef BPU_GSHARE_EN
    i = i ^ m_ghr;
`endif
    return i;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int i;
    i = m_index(pc);
    return m_v[i] && (m_tag[i] == longint'(pc / 64));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) m_v[i] = 1'b0;
    m_ghr = 0;
    m_res = 0;
    m_mis = 0;
  endtask

  task automatic model_clock(input bit r, input bit v, input bit br, input bit j, input bit tk,
                             input logic [31:0] pc, input logic [31:0] tgt, input bit mp);
    int  i;
    bit  hit;
    if (r) begin
      model_reset();
      return;
    end
    if (!(v && (br || j))) return;
    i   = m_index(pc);
    hit = m_hit(pc);
    if (m_res < STAT_MAX) m_res++;
    if (mp && m_mis < STAT_MAX) m_mis++;
    if (j) begin
      m_v[i] = 1; m_tag[i] = pc / 64; m_tgt[i] = tgt; m_j[i] = 1; m_cnt[i] = 3;
    end else begin
      if (hit) begin
        m_cnt[i] = tk ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3) : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
        if (tk) m_tgt[i] = tgt;
        m_j[i] = 0;
      end else if (tk) begin
        m_v[i] = 1; m_tag[i] = pc / 64; m_tgt[i] = tgt; m_j[i] = 0; m_cnt[i] = 2;
      end
`ifdef BPU_GSHARE_EN
      m_ghr = ((m_ghr << 1) | int'(tk)) & ((1 << GHR_W) - 1);
`endif
    end
  endtask

  // ---------------- driver tasks ----------------
  // drive: apply inputs at the falling edge and check the lookup before the next rising edge.
  task automatic drive(input logic [31:0] pc, input bit r, input bit v, input bit br, input bit j,
                       input bit tk, input logic [31:0] tgt, input bit mp);
    int          i;
    bit          et;
    logic [31:0] ep;
    @(negedge clk);
    rst                          = r;
    fetch_pc                     = pc;
    exe_bus.execute_i_valid      = v;
    exe_bus.execute_i_pc         = pc;
    exe_bus.execute_i_is_branch  = br;
    exe_bus.execute_i_is_jump    = j;
    exe_bus.execute_i_taken      = tk;
    exe_bus.execute_i_target     = tgt;
    exe_bus.execute_i_mispredict = mp;
    #1;
    i  = m_index(pc);
    et = !r && m_hit(pc) && (m_j[i] || m_cnt[i] >= 2);
    ep = et ? m_tgt[i] : pc + 32'd4;
    exp_q.push_back(64'(et));
    exp_q.push_back(64'(ep));
    exp_q.push_back(m_res);
    exp_q.push_back(m_mis);
    exp_q.push_back(64'(m_ghr));
    check("taken",       64'(taken),       exp_q.pop_front());
    check("pre_pc",      64'(pre_pc),      exp_q.pop_front());
    check("resolve_cnt", 64'(resolve_cnt), exp_q.pop_front());
    check("mispred_cnt", 64'(mispred_cnt), exp_q.pop_front());
    check("ghr",         64'(ghr),         exp_q.pop_front());
  endtask

  // step: full cycle where fetch pc and execute pc may differ.
  task automatic step(input logic [31:0] fpc, input bit r, input bit v, input bit br, input bit j,
                      input bit tk, input logic [31:0] epc, input logic [31:0] tgt, input bit mp);
    drive(fpc, r, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    exe_bus.execute_i_valid      = v;
    exe_bus.execute_i_pc         = epc;
    exe_bus.execute_i_is_branch  = br;
    exe_bus.execute_i_is_jump    = j;
    exe_bus.execute_i_taken      = tk;
    exe_bus.execute_i_target     = tgt;
    exe_bus.execute_i_mispredict = mp;
    @(posedge clk);
    model_clock(r, v, br, j, tk, epc, tgt, mp);
  endtask

  // same_pc: lookup and update of one PC in the same cycle.
  task automatic same_pc(input logic [31:0] pc, input bit br, input bit j, input bit tk,
                         input logic [31:0] tgt, input bit mp);
    drive(pc, 1'b0, 1'b1, br, j, tk, tgt, mp);
    @(posedge clk);
    model_clock(1'b0, 1'b1, br, j, tk, pc, tgt, mp);
  endtask

  task automatic look(input logic [31:0] pc);
    drive(pc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst                     = 1'b1;
    exe_bus.execute_i_valid = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 19) == 0) return 32'hFFFF_FFFC;
    return 32'h8000_0000 + 32'($urandom_range(0, 63)) * 4;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst                          = 1'b1;
    fetch_pc                     = 32'h8000_0000;
    exe_bus.execute_i_valid      = 1'b0;
    exe_bus.execute_i_pc         = '0;
    exe_bus.execute_i_is_branch  = 1'b0;
    exe_bus.execute_i_is_jump    = 1'b0;
    exe_bus.execute_i_taken      = 1'b0;
    exe_bus.execute_i_target     = '0;
    exe_bus.execute_i_mispredict = 1'b0;
    model_reset();

    // Reset state
    do_reset();
    look(32'h8000_0000);
    check("rst_pre_pc",  64'(pre_pc),      64'h8000_0004);
    check("rst_taken",   64'(taken),       64'h0);
    check("rst_resolve", 64'(resolve_cnt), 64'h0);
    check("rst_mispred", 64'(mispred_cnt), 64'h0);

    // Jump training
    step(32'h8000_0000, 0, 1, 0, 1, 1, 32'h8000_0010, 32'h8000_0100, 1);
    look(32'h8000_0010);
    check("jal_pre_pc", 64'(pre_pc), 64'h8000_0100);
    check("jal_taken",  64'(taken),  64'h1);

    // Direction hysteresis
    step(32'h8000_0000, 0, 1, 1, 0, 1, 32'h8000_0020, 32'h8000_0200, 1);
    step(32'h8000_0000, 0, 1, 1, 0, 1, 32'h8000_0020, 32'h8000_0200, 0);
    look(32'h8000_0020);
    step(32'h8000_0000, 0, 1, 1, 0, 0, 32'h8000_0020, 32'h8000_0200, 1);
    look(32'h8000_0020);
    step(32'h8000_0000, 0, 1, 1, 0, 0, 32'h8000_0020, 32'h8000_0200, 1);
    look(32'h8000_0020);

    // Aliasing
    step(32'h8000_0000, 0, 1, 1, 0, 1, 32'h8000_0020, 32'h8000_0200, 0);
    look(32'h8000_0060);
    step(32'h8000_0000, 0, 1, 1, 0, 1, 32'h8000_0060, 32'h8000_0600, 1);
    look(32'h8000_0060);
    look(32'h8000_0020);

    // Same-cycle update and lookup
    do_reset();
    same_pc(32'h8000_0030, 0, 1, 1, 32'h8000_0300, 1);
    check("same_old_pre_pc", 64'(pre_pc), 64'h8000_0034);
    look(32'h8000_0030);
    check("same_new_pre_pc", 64'(pre_pc), 64'h8000_0300);
    same_pc(32'h8000_0040, 1, 0, 0, 32'h8000_0400, 0);
    look(32'h8000_0040);
    check("nt_miss_pre_pc", 64'(pre_pc), 64'h8000_0044);

    // Statistics, GHR, mid-sequence reset
    do_reset();
    step(32'h8000_0000, 0, 1, 1, 0, 1, 32'h8000_0040, 32'h8000_0400, 0);
    step(32'h8000_0000, 0, 1, 1, 0, 1, 32'h8000_0044, 32'h8000_0440, 1);
    step(32'h8000_0000, 0, 1, 1, 0, 0, 32'h8000_0048, 32'h8000_0480, 0);
    look(32'h8000_0000);
    check("stat_resolve", 64'(resolve_cnt), 64'd3);
    check("stat_mispred", 64'(mispred_cnt), 64'd1);
`ifdef BPU_GSHARE_EN
    check("stat_ghr", 64'(ghr), 64'h6);
`else
    check("stat_ghr", 64'(ghr), 64'h0);
`endif
    step(32'h8000_0050, 1, 1, 0, 1, 1, 32'h8000_0050, 32'h8000_0500, 1);
    look(32'h8000_0050);
    check("mid_rst_resolve", 64'(resolve_cnt), 64'd0);
    check("mid_rst_mispred", 64'(mispred_cnt), 64'd0);
    check("mid_rst_ghr",     64'(ghr),         64'h0);
    check("mid_rst_pre_pc",  64'(pre_pc),      64'h8000_0054);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit          r, v, br, j, tk, mp;
      logic [31:0] fpc, epc, tgt;
      r   = ($urandom_range(0, 99) == 0);
      v   = ($urandom_range(0, 9) < 7);
      br  = $urandom_range(0, 1);
      j   = ($urandom_range(0, 3) == 0);
      tk  = $urandom_range(0, 1);
      mp  = $urandom_range(0, 1);
      tgt = $urandom() & 32'hFFFF_FFFC;
      epc = rand_pc();
      fpc = ($urandom_range(0, 3) == 0) ? epc : rand_pc();
      step(fpc, r, v, br, j, tk, epc, tgt, mp);
    end
    look(32'h8000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
